// File: rtl/param_pipe_reg.sv
// Parameterised valid/ready register pipeline with bubble collapsing, flush and occupancy count.
// Asynchronous active-high reset drives every stage to RESET_VAL.
module param_pipe_reg #(
    parameter int             W         = 32,
    parameter int             DEPTH     = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    logic [W-1:0]     r_data [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_stage_in_valid;
    logic [W-1:0]     w_stage_in_data [DEPTH];
    logic             w_push;
    logic             w_pop;

    // A stage can take a word when the sink is ready or any stage from it to the
    // output end is empty; this is the unrolled form of "next stage empty or advancing".
    for (genvar j = 0; j < DEPTH; j++) begin : g_stage
        assign w_ready[j] = out_ready | ~(&r_valid[DEPTH-1:j]);
        if (j == 0) begin : g_head
            assign w_stage_in_valid[j] = w_push;
            assign w_stage_in_data[j]  = in_data;
        end else begin : g_body
            assign w_stage_in_valid[j] = r_valid[j-1];
            assign w_stage_in_data[j]  = r_data[j-1];
        end
    end

    assign in_ready  = ~resetn & ~flush & w_ready[0];
    assign out_valid = r_valid[DEPTH-1] & ~flush;
    assign out_data  = r_data[DEPTH-1];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // NOTE: data registers are reset because out_data must show RESET_VAL during reset;
    // state uses <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_valid <= '0;
            for (int j = 0; j < DEPTH; j++) r_data[j] <= RESET_VAL;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (w_ready[j]) begin
                    r_valid[j] <= w_stage_in_valid[j];
                    // Emptied stages keep their old data.
                    if (w_stage_in_valid[j]) r_data[j] <= w_stage_in_data[j];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: doc/param_pipe_reg.md
PARAM_PIPE_REG -- requirements
Module: param_pipe_reg

Interface
REQ-001 The block SHALL provide parameter W, default 32, meaning data width in bits (legal 1..64).
REQ-002 The block SHALL provide parameter DEPTH, default 4, meaning number of register stages (legal 1..16).
REQ-003 The block SHALL provide parameter RESET_VAL, default 0 (W bits), meaning reset value of every stage data register.
REQ-004 clk  input  1  clock; all state SHALL change on its rising edge only, except on reset.
REQ-005 resetn  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all stage contents.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  pipeline accepts a word this cycle.
REQ-009 in_data  input  W  upstream word.
REQ-010 out_valid  output  1  last stage holds a word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  W  last-stage word.
REQ-013 count  output  clog2(DEPTH+1)  number of occupied stages.
REQ-014 full, empty  output  1 each  count==DEPTH and count==0 respectively.

Function
REQ-015 Each stage i (0..DEPTH-1) SHALL hold one data register (W bits) and one valid bit; stage 0 is the input end, and stage DEPTH-1 drives out_data/out_valid.
REQ-016 Transfers SHALL occur on a rising edge only when valid and ready are both high on the same side; data SHALL not be lost, duplicated or reordered.
REQ-017 Stage DEPTH-1 SHALL advance when out_ready=1 or the stage is empty; stage i<DEPTH-1 SHALL advance into stage i+1 when stage i+1 is empty or itself advancing (bubble collapsing).
REQ-018 in_ready SHALL equal (stage 0 empty) or (stage 0 advancing); it is combinational from out_ready and the valid bits, and SHALL not depend on in_valid.
REQ-019 Latency: a word accepted at edge N into an empty pipeline with out_ready=1 SHALL appear on out_valid/out_data immediately after edge N+DEPTH-1.
REQ-020 Throughput SHALL be one word per cycle while in_valid=1 and out_ready=1 continuously.
REQ-021 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-022 Data registers of empty stages SHALL keep their last value; they are not cleared when emptied.
REQ-023 count SHALL update every edge by +1 on accept only, -1 on output transfer only, and 0 change on both or neither; it SHALL never exceed DEPTH nor wrap below 0.
REQ-024 Full boundary: with count==DEPTH and out_ready=0, in_ready SHALL be 0; with out_ready=1, in_ready SHALL be 1 in the same cycle and accept and output SHALL occur on the same edge.
REQ-025 Empty boundary: with count==0, out_valid SHALL be 0 and out_ready SHALL have no effect.
REQ-026 While flush=1: in_ready and out_valid SHALL be forced 0, no transfer SHALL occur, and all valid bits and count SHALL be 0 after the edge; data registers SHALL remain unchanged.
REQ-027 flush SHALL take priority over simultaneous in_valid/out_ready activity.

Reset
REQ-028 While resetn=1, all valid bits SHALL be 0 and all data registers RESET_VAL immediately, without waiting for clk; count=0, out_valid=0, empty=1, full=0, out_data=RESET_VAL.
REQ-029 When resetn is asserted mid-operation, all in-flight words SHALL be discarded; after release, the first accepted word SHALL follow the REQ-019 latency.
REQ-030 in_ready SHALL be 0 while resetn=1.

Verification (W=32, DEPTH=4 unless stated)
REQ-031 Reset: assert resetn with 3 words in flight -> out_valid=0, count=0, out_data=0 before the next clk edge.
REQ-032 Latency: push 0xDEADBEEF at edge 1 with out_ready=1 -> out_valid=1, out_data=0xDEADBEEF after edge 4, out_valid=0 after edge 5.
REQ-033 Streaming: push 10 $random words on consecutive edges with out_ready=1 -> identical sequence out, in_ready constantly 1, count stays 3..4.
REQ-034 Backpressure: out_ready=0 with 6 words offered -> exactly 4 accepted, full=1, in_ready=0; raise out_ready -> in_ready=1 that cycle; all words drain in order.
REQ-035 Flush: 3 words held, pulse flush one cycle together with in_valid=1 -> nothing accepted, count=0, out_valid=0; next word latency per REQ-032.
REQ-036 Narrow instance W=9, DEPTH=1, RESET_VAL=9'h1A5 -> out_data=9'h1A5 in reset; word 9'h0FF out after the acceptance edge; a simultaneous push and pop when full is accepted.
